// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq: sequences one fully-connected layer over a shared
// single-MAC neuron datapath. For each output neuron the bias is loaded,
// then N_IN multiply-accumulate steps run through the external datapath,
// and the result leaves through a valid/ready port.
// Optional build macro: NARNET_RELU_EN (applies ReLU to the emitted value only).
`timescale 1ns/1ps
module neuron_layer_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  localparam int XW = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int BW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int WW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_addr,
  input  logic [7:0]    x_data,
  output logic [WW-1:0] w_addr,
  input  logic [7:0]    w_data,
  output logic [BW-1:0] b_addr,
  input  logic [7:0]    b_data,
  output logic [7:0]    n_w,
  output logic [7:0]    n_x,
  output logic [7:0]    n_b,
  input  logic [7:0]    n_out,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [BW-1:0] y_idx,
  output logic [7:0]    y_data
);

  typedef enum logic [2:0] {IDLE, BRD, BLD, RD, MAC, EMIT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    acc_reg, acc_next;
  logic [BW-1:0] o_reg, o_next;
  logic [XW-1:0] i_reg, i_next;
  logic [XW-1:0] x_hold_reg;
  logic [WW-1:0] w_hold_reg;
  logic [BW-1:0] b_hold_reg;
  logic [WW-1:0] w_calc;
  logic [7:0]    y_value;

  // Flat weight address for neuron o, input i.
  assign w_calc = WW'(o_reg) * WW'(N_IN) + WW'(i_reg);

  // Emitted value; the accumulator itself is never modified by ReLU.
`ifdef NARNET_RELU_EN
  assign y_value = acc_reg[7] ? 8'h00 : acc_reg;
`else
  assign y_value = acc_reg;
`endif

  // State, counters, accumulator and held addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      acc_reg    <= 8'h00;
      o_reg      <= '0;
      i_reg      <= '0;
      x_hold_reg <= '0;
      w_hold_reg <= '0;
      b_hold_reg <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      o_reg      <= o_next;
      i_reg      <= i_next;
      x_hold_reg <= x_addr;
      w_hold_reg <= w_addr;
      b_hold_reg <= b_addr;
    end
  end

  // Datapath operands live in their own block so the n_* -> n_out -> acc_next
  // path through the external datapath is not seen as a loop.
  always_comb begin
    n_w = 8'h00;
    n_x = 8'h00;
    n_b = 8'h00;
    if (state_reg == MAC) begin
      n_w = w_data;
      n_x = x_data;
      n_b = acc_reg;
    end
  end

  // Next-state logic and control outputs; addresses hold unless driven.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    o_next     = o_reg;
    i_next     = i_reg;
    busy       = 1'b1;
    done       = 1'b0;
    y_valid    = 1'b0;
    y_idx      = '0;
    y_data     = 8'h00;
    x_addr     = x_hold_reg;
    w_addr     = w_hold_reg;
    b_addr     = b_hold_reg;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          o_next     = '0;
          i_next     = '0;
          state_next = BRD;
        end
      end
      BRD: begin
        b_addr     = o_reg;
        state_next = BLD;
      end
      BLD: begin
        acc_next   = b_data;
        i_next     = '0;
        state_next = RD;
      end
      RD: begin
        x_addr     = i_reg;
        w_addr     = w_calc;
        state_next = MAC;
      end
      MAC: begin
        acc_next = n_out;
        if (i_reg == XW'(N_IN - 1)) begin
          state_next = EMIT;
        end else begin
          i_next     = i_reg + 1'b1;
          state_next = RD;
        end
      end
      EMIT: begin
        y_valid = 1'b1;
        y_idx   = o_reg;
        y_data  = y_value;
        if (y_ready) begin
          if (o_reg == BW'(N_OUT - 1)) begin
            state_next = DONE;
          end else begin
            o_next     = o_reg + 1'b1;
            state_next = BRD;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Testbench for neuron_layer_seq: synchronous-read memories, a behavioural
// neuron datapath, and a golden layer model computed from plain arithmetic.
`timescale 1ns/1ps
module tb_neuron_layer_seq;
  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int XW = 2;
  localparam int BW = 2;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [XW-1:0] x_addr;
  logic [7:0]    x_data;
  logic [WW-1:0] w_addr;
  logic [7:0]    w_data;
  logic [BW-1:0] b_addr;
  logic [7:0]    b_data;
  logic [7:0]    n_w, n_x, n_b, n_out;
  logic          y_valid;
  logic          y_ready = 1'b1;
  logic [BW-1:0] y_idx;
  logic [7:0]    y_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] xmem [N_IN];
  logic [7:0] wmem [N_IN*N_OUT];
  logic [7:0] bmem [N_OUT];
  logic [7:0] exp_y [N_OUT];
  logic [7:0] ys [N_OUT];
  int         nres;
  int         wseq[$];
  int         xseq[$];

  neuron_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .n_w(n_w), .n_x(n_x), .n_b(n_b),
    .n_out(n_out), .y_valid(y_valid), .y_ready(y_ready), .y_idx(y_idx),
    .y_data(y_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffers, one cycle of latency.
  always @(posedge clk) begin
    x_data <= xmem[x_addr];
    w_data <= wmem[w_addr];
    b_data <= bmem[b_addr];
  end

  // Neuron datapath: n_b + floor(n_w*n_x / 128), wrapping to 8 bits.
  logic signed [15:0] prod;
  assign prod  = $signed(n_w) * $signed(n_x);
  assign n_out = n_b + prod[14:7];

  // Golden result for neuron o from the layer's arithmetic definition.
  function automatic logic [7:0] model_y(int o);
    int acc;
    logic [7:0] r;
    acc = int'($signed(bmem[o]));
    for (int i = 0; i < N_IN; i++)
      acc = acc + ((int'($signed(wmem[o*N_IN+i])) * int'($signed(xmem[i]))) >>> 7);
    r = acc[7:0];
`ifdef NARNET_RELU_EN
    if (r[7]) r = 8'h00;
`endif
    return r;
  endfunction

  task automatic fill_const(input logic [7:0] w, input logic [7:0] x, input logic [7:0] b);
    for (int k = 0; k < N_IN*N_OUT; k++) wmem[k] = w;
    for (int k = 0; k < N_IN; k++) xmem[k] = x;
    for (int k = 0; k < N_OUT; k++) bmem[k] = b;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N_IN*N_OUT; k++) wmem[k] = 8'($urandom);
    for (int k = 0; k < N_IN; k++) xmem[k] = 8'($urandom) | 8'h01;
    for (int k = 0; k < N_OUT; k++) bmem[k] = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%0b expected 0", busy);
    end
  endtask

  // Runs one layer from start to the DONE cycle, acting as the downstream
  // consumer and checking every result, handshake stability and operand use.
  task automatic run_layer(input int stall, input bit busy_starts, output int done_cyc);
    int cyc, stall_cnt;
    bit held;
    logic [BW-1:0] h_idx;
    logic [7:0] h_data;
    logic [WW-1:0] pw;
    logic [XW-1:0] px;
    wait_idle();
    for (int o = 0; o < N_OUT; o++) exp_y[o] = model_y(o);
    nres = 0; stall_cnt = 0; held = 0; done_cyc = -1;
    h_idx = '0; h_data = '0;
    wseq.delete(); xseq.delete();
    pw = w_addr; px = x_addr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= 300) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_high cyc=%0d busy=%0b expected 1", cyc, busy);
      end
      if (n_x !== 8'h00) begin
        wseq.push_back(int'(pw));
        xseq.push_back(int'(px));
        checks++;
        if (n_w !== wmem[pw] || n_x !== xmem[px]) begin
          errors++;
          $display("FAIL operand cyc=%0d n_w=%h n_x=%h expected %h %h", cyc, n_w, n_x, wmem[pw], xmem[px]);
        end
      end
      if (y_valid) begin
        checks++;
        if ({n_w, n_x, n_b} !== 24'h0) begin
          errors++;
          $display("FAIL emit_idle cyc=%0d n_w=%h n_x=%h n_b=%h expected 0", cyc, n_w, n_x, n_b);
        end
        if (held) begin
          checks++;
          if (y_idx !== h_idx || y_data !== h_data) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d idx=%0d data=%h expected %0d %h", cyc, y_idx, y_data, h_idx, h_data);
          end
        end
        if (stall_cnt >= stall) begin
          y_ready = 1'b1;
          checks++;
          if (nres >= N_OUT || y_idx !== BW'(nres) || y_data !== exp_y[nres % N_OUT]) begin
            errors++;
            $display("FAIL result cyc=%0d idx=%0d data=%h expected %0d %h", cyc, y_idx, y_data, nres, exp_y[nres % N_OUT]);
          end
          if (nres < N_OUT) ys[nres] = y_data;
          $display("result %0d idx=%0d data=%h cyc=%0d", nres, y_idx, y_data, cyc);
          nres++; stall_cnt = 0; held = 0;
        end else begin
          y_ready = 1'b0;
          stall_cnt++; held = 1; h_idx = y_idx; h_data = y_data;
        end
      end else begin
        y_ready = 1'($urandom);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = busy_starts && (cyc == 5 || cyc == 20 || cyc == 33);
      pw = w_addr; px = x_addr;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    y_ready = 1'b1;
    checks++;
    if (done_cyc < 0 || nres !== N_OUT) begin
      errors++;
      $display("FAIL layer_end done_cyc=%0d results=%0d expected done and %0d", done_cyc, nres, N_OUT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, y_valid, y_idx, y_data, x_addr, w_addr, b_addr, n_w, n_x, n_b} !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%0b done=%0b yv=%0b yd=%h n_b=%h expected all 0", busy, done, y_valid, y_data, n_b);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_defaults();
    int dc;
    fill_const(8'h40, 8'h20, 8'h08);
    run_layer(0, 0, dc);
    for (int o = 0; o < N_OUT; o++) begin
      checks++;
      if (ys[o] !== 8'h48) begin
        errors++;
        $display("FAIL defaults_y%0d got %h expected 48", o, ys[o]);
      end
    end
    checks++;
    if (dc !== 45) begin
      errors++;
      $display("FAIL defaults_done got %0d expected 45", dc);
    end
  endtask

  task automatic test_const(input logic [7:0] w, input logic [7:0] x, input logic [7:0] b,
                            input logic [7:0] raw, input logic [7:0] relu);
    int dc;
    logic [7:0] req;
`ifdef NARNET_RELU_EN
    req = relu;
`else
    req = raw;
`endif
    fill_const(w, x, b);
    run_layer(0, 0, dc);
    checks++;
    if (ys[0] !== req || ys[N_OUT-1] !== req) begin
      errors++;
      $display("FAIL const_w%h_x%h_b%h got %h/%h expected %h", w, x, b, ys[0], ys[N_OUT-1], req);
    end
  endtask

  task automatic test_addr_seq();
    int dc;
    for (int k = 0; k < N_IN*N_OUT; k++) wmem[k] = 8'(k);
    for (int k = 0; k < N_IN; k++) xmem[k] = 8'h7F;
    for (int k = 0; k < N_OUT; k++) bmem[k] = 8'($urandom);
    run_layer(0, 0, dc);
    checks++;
    if (wseq.size() != N_IN*N_OUT) begin
      errors++;
      $display("FAIL addr_count got %0d expected %0d", wseq.size(), N_IN*N_OUT);
    end else begin
      for (int k = 0; k < N_IN*N_OUT; k++) begin
        checks++;
        if (wseq[k] != k || xseq[k] != k % N_IN) begin
          errors++;
          $display("FAIL addr_seq k=%0d w_addr=%0d x_addr=%0d expected %0d %0d", k, wseq[k], xseq[k], k, k % N_IN);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int dc;
    fill_rand();
    run_layer(5, 0, dc);
    checks++;
    if (dc !== 65) begin
      errors++;
      $display("FAIL backpressure_done got %0d expected 65", dc);
    end
  endtask

  task automatic test_busy_start();
    int dc;
    fill_rand();
    run_layer(0, 1, dc);
    checks++;
    if (dc !== 45) begin
      errors++;
      $display("FAIL busy_start_done got %0d expected 45", dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    fill_rand();
    run_layer(0, 0, dc);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%0b done=%0b expected 0 0", busy, done);
    end
    fill_rand();
    run_layer(0, 0, dc);
    checks++;
    if (dc !== 45) begin
      errors++;
      $display("FAIL b2b_done got %0d expected 45", dc);
    end
  endtask

  task automatic test_reset_mid();
    int dc, seen;
    wait_idle();
    fill_rand();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Cycle 26 is the first MAC of neuron 2.
    for (int c = 1; c < 26; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (n_x !== xmem[0]) begin
      errors++;
      $display("FAIL mid_in_mac n_x=%h expected %h", n_x, xmem[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, y_valid, y_idx, y_data, x_addr, w_addr, b_addr, n_w, n_x, n_b} !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%0b yv=%0b n_w=%h n_x=%h n_b=%h expected all 0", busy, y_valid, n_w, n_x, n_b);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (y_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_quiet active_cycles=%0d expected 0", seen);
    end
    $display("mid-layer reset observed");
    fill_rand();
    run_layer(0, 0, dc);
    checks++;
    if (dc !== 45) begin
      errors++;
      $display("FAIL mid_restart_done got %0d expected 45", dc);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_const(8'h40, 8'h40, 8'h00, 8'h80, 8'h00);
    test_const(8'hC0, 8'h40, 8'h10, 8'h90, 8'h00);
    test_const(8'hFF, 8'h01, 8'h00, 8'hFC, 8'h00);
    test_addr_seq();
    test_backpressure();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_busy_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_layer_seq.md
# neuron_layer_seq

Sequencer for one fully-connected layer built on the shared single-MAC neuron datapath (n_out = n_b + ((n_w·n_x) bits [14:7]), 8-bit Q1.7, wrapping). For each of N_OUT output neurons it loads the bias, then time-multiplexes the datapath over N_IN inputs, feeding the running accumulator back into n_b. It fetches operands from three synchronous-read memories and emits each result through a valid/ready port. It sits between the weight/input buffers and the next layer's input buffer.

## Interface
- N_IN, 4, inputs per output neuron (≥1)
- N_OUT, 4, output neurons per layer (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted
- x_addr  out  clog2(N_IN)  input-buffer address (= i)
- x_data  in  8  input value, valid the cycle after x_addr
- w_addr  out  clog2(N_IN·N_OUT)  weight address (= o·N_IN + i)
- w_data  in  8  weight, valid the cycle after w_addr
- b_addr  out  clog2(N_OUT)  bias address (= o)
- b_data  in  8  bias, valid the cycle after b_addr
- n_w, n_x, n_b  out  8 each  neuron datapath operands
- n_out  in  8  neuron datapath result (combinational from n_w/n_x/n_b)
- y_valid  out  1  result valid
- y_ready  in  1  downstream accepts
- y_idx  out  clog2(N_OUT)  output neuron index o
- y_data  out  8  result, signed Q1.7

## Operation
- FSM states: IDLE, BRD, BLD, RD, MAC, EMIT, DONE.
- IDLE: start=1 → clear o, i → BRD. start is ignored in all other states.
- BRD: drive b_addr=o → BLD.
- BLD: acc ← b_data; i ← 0 → RD.
- RD: drive x_addr=i and w_addr=o·N_IN+i → MAC.
- MAC: n_w=w_data, n_x=x_data, n_b=acc; acc ← n_out. If i=N_IN−1, go to EMIT; otherwise i ← i+1 and go to RD.
- EMIT: y_valid=1, y_idx=o, y_data=f(acc). Hold until y_ready=1. On that handshake: if o=N_OUT−1, go to DONE; otherwise o ← o+1 and go to BRD.
- DONE: done=1 → IDLE.
- Arithmetic: the accumulator is 8 bits and wraps modulo 256, with no saturation, matching the datapath. The product is floored (arithmetic shift), e.g. 0xFF·0x01 → 0xFF.
- n_w/n_x/n_b are 0 outside MAC. Addresses hold their last value when not in use.
- Reset (rst=0), at any time including mid-layer: state=IDLE, acc/o/i=0, and busy, done, y_valid, y_idx, y_data, all addresses and all n_* are 0. No partial result is emitted afterwards.

## Timing
- Memory read latency is exactly 1 cycle. The address is driven in BRD/RD, and the data is consumed in BLD/MAC.
- Per output neuron: 3 + 2·N_IN cycles plus any y_ready stall cycles.
- Total with y_ready tied high: BRD is entered on the edge that samples start, and done is high in cycle N_OUT·(3+2·N_IN)+1. With the defaults, done is in cycle 45.
- y_valid, y_idx and y_data stay stable while y_valid=1 and y_ready=0.
- y_ready high outside EMIT has no effect.
- busy falls on the edge leaving DONE. A start in that same IDLE cycle is accepted.

## Configuration
- NARNET_RELU_EN defined: in EMIT, y_data = acc[7] ? 0x00 : acc. Only the emitted value is affected; acc is unchanged.
- NARNET_RELU_EN undefined: y_data = acc, raw and signed.

## Test plan
- Defaults, all w=0x40, x=0x20, b=0x08, y_ready=1. Required: four results of 0x48 with y_idx 0..3, and done in cycle 45.
- All w=0x40, x=0x40, b=0x00. Required: y_data=0x80 (wrap to −128) without NARNET_RELU_EN, and 0x00 with it.
- w=0xC0, x=0x40, b=0x10. Required: y_data=0x90 without ReLU, 0x00 with ReLU. Also check w=0xFF, x=0x01, b=0 gives 0xFC (floor per MAC).
- Distinct weights w[k]=k, x=0x7F. Required: w_addr sequence 0..15 and x_addr cycling 0..3 four times, each address held one cycle before its data is used. y_data per neuron matches the golden model.
- Backpressure: y_ready low for 5 cycles at each EMIT. Required: y_valid/y_idx/y_data held stable, no MAC activity during the stall, and done in cycle 45+20.
- Drop rst for 1 cycle during MAC of o=2. Required: all outputs 0 immediately and no further y_valid. A new start then gives the full, correct four-result sequence. Also check that start pulses while busy are ignored.
